// File: rtl/core_memory_pkg.sv
// core_memory_pkg: shared types and constants for the core_memory block.
//   state_e      - controller phases: clear data memory, accept program, run core
//   word_t       - 32-bit memory word
//   DefImWords / DefDmWords - default memory depths in words
//   addr_in_range - byte address falls inside a memory of the given word depth
package core_memory_pkg;

    localparam int unsigned WordWidth  = 32;
    localparam int unsigned DefImWords = 1024;
    localparam int unsigned DefDmWords = 1024;

    typedef logic [WordWidth-1:0] word_t;

    typedef enum logic [1:0] {
        StClear,
        StLoad,
        StRun
    } state_e;

    // Compare the word index rather than addr < 4*words so the product cannot overflow.
    function automatic logic addr_in_range(input word_t addr, input int unsigned words);
        return (addr >> 2) < word_t'(words);
    endfunction

endpackage

// File: rtl/core_memory_if.sv
// core_memory_if: core and program-loader bus of core_memory.
//   addIM/dataIM           - instruction fetch address / returned word
//   addDM/dataDM           - data access address / returned word
//   wenDM/dataOUT          - data store enable / store data
//   ld_valid/ld_ready      - program-load handshake
//   ld_data/ld_last        - program word / final-word marker
//   core_reset/fault       - core hold-in-reset / sticky error flag
// Modports: slave (the memory block), master (core + loader side).
interface core_memory_if;
    import core_memory_pkg::*;

    word_t addIM;
    word_t dataIM;
    word_t addDM;
    word_t dataDM;
    logic  wenDM;
    word_t dataOUT;
    logic  ld_valid;
    logic  ld_ready;
    word_t ld_data;
    logic  ld_last;
    logic  core_reset;
    logic  fault;

    modport slave (
        input  addIM, addDM, wenDM, dataOUT, ld_valid, ld_data, ld_last,
        output dataIM, dataDM, ld_ready, core_reset, fault
    );

    modport master (
        output addIM, addDM, wenDM, dataOUT, ld_valid, ld_data, ld_last,
        input  dataIM, dataDM, ld_ready, core_reset, fault
    );

endinterface

// File: rtl/mem_word_ram.sv
// mem_word_ram: word-wide RAM, one write port and one registered read port.
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write word index
//   wdata_i - write data
//   raddr_i - read word index, data appears on rdata_o after the next edge
//   rdata_o - registered read data; a same-edge write to raddr_i returns old data
module mem_word_ram
    import core_memory_pkg::*;
#(
    parameter int unsigned Words = DefDmWords,
    localparam int unsigned Aw   = $clog2(Words)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output word_t         rdata_o
);

    word_t mem_q [Words];
    word_t rdata_q;

    // Non-blocking read and write on the same edge gives read-before-write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_memory.sv
// core_memory: instruction + data memory for a small core, with program loading.
// After reset it zeroes data memory one word per cycle (CLEAR), then accepts program
// words over a valid/ready stream into instruction memory (LOAD), then releases the
// core and serves registered reads and data stores (RUN).
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset, forces CLEAR
//   bus   - core_memory_if.slave: core fetch/data ports, loader stream, core_reset, fault
module core_memory
    import core_memory_pkg::*;
#(
    parameter int unsigned IM_WORDS = DefImWords,
    parameter int unsigned DM_WORDS = DefDmWords
) (
    input logic          clk,
    input logic          reset,
    core_memory_if.slave bus
);

    localparam int unsigned ImAw = $clog2(IM_WORDS);
    localparam int unsigned DmAw = $clog2(DM_WORDS);

    state_e            state_q, state_d;
    logic [ImAw-1:0]   wptr_q;
    logic [DmAw-1:0]   clr_cnt_q;
    logic              fault_q;
    logic              core_reset_q;
    logic              ld_ready_q;
    logic              im_rd_ok_q;
    logic              dm_rd_ok_q;

    logic              in_clear, in_load, in_run;
    logic              load_acc, wptr_full;
    logic              im_in_range, dm_in_range, dm_wr_ok;
    logic              fault_set;
    logic              dm_we;
    logic [DmAw-1:0]   dm_waddr;
    word_t             dm_wdata;
    word_t             im_rdata, dm_rdata;

    always_comb begin
        in_clear    = (state_q == StClear);
        in_load     = (state_q == StLoad);
        in_run      = (state_q == StRun);
        load_acc    = in_load & bus.ld_valid;
        wptr_full   = (wptr_q == ImAw'(IM_WORDS - 1));
        im_in_range = addr_in_range(bus.addIM, IM_WORDS);
        dm_in_range = addr_in_range(bus.addDM, DM_WORDS);
        dm_wr_ok    = (bus.addDM[1:0] == 2'b00) & dm_in_range;

        // The data port is shared: the clear sweep owns it until RUN.
        dm_we    = in_clear | (in_run & bus.wenDM & dm_wr_ok);
        dm_waddr = in_clear ? clr_cnt_q : bus.addDM[DmAw+1:2];
        dm_wdata = in_clear ? '0 : bus.dataOUT;

        // Both read ports sample every RUN cycle, so an out-of-range address is a fault
        // even without a store.
        fault_set = (in_run & ((bus.wenDM & ~dm_wr_ok) | ~im_in_range | ~dm_in_range))
                  | (load_acc & ~bus.ld_last & wptr_full);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_cnt_q == DmAw'(DM_WORDS - 1)) state_d = StLoad;
            StLoad:  if (load_acc & (bus.ld_last | wptr_full)) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StClear;
            wptr_q       <= '0;
            clr_cnt_q    <= '0;
            fault_q      <= 1'b0;
            core_reset_q <= 1'b1;
            ld_ready_q   <= 1'b0;
            im_rd_ok_q   <= 1'b0;
            dm_rd_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (in_clear) clr_cnt_q <= clr_cnt_q + 1'b1;
            if (load_acc) wptr_q    <= wptr_q + 1'b1;
            fault_q      <= fault_q | fault_set;
            // Outputs follow the next state so they change on the same edge as the phase.
            core_reset_q <= (state_d != StRun);
            ld_ready_q   <= (state_d == StLoad);
            im_rd_ok_q   <= in_run & im_in_range;
            dm_rd_ok_q   <= in_run & dm_in_range;
        end
    end

    mem_word_ram #(
        .Words(IM_WORDS)
    ) u_im (
        .clk_i  (clk),
        .we_i   (load_acc),
        .waddr_i(wptr_q),
        .wdata_i(bus.ld_data),
        .raddr_i(bus.addIM[ImAw+1:2]),
        .rdata_o(im_rdata)
    );

    mem_word_ram #(
        .Words(DM_WORDS)
    ) u_dm (
        .clk_i  (clk),
        .we_i   (dm_we),
        .waddr_i(dm_waddr),
        .wdata_i(dm_wdata),
        .raddr_i(bus.addDM[DmAw+1:2]),
        .rdata_o(dm_rdata)
    );

    // RAM read registers are unreset; the qualifying flags force 0 outside RUN.
    assign bus.dataIM     = im_rd_ok_q ? im_rdata : '0;
    assign bus.dataDM     = dm_rd_ok_q ? dm_rdata : '0;
    assign bus.ld_ready   = ld_ready_q;
    assign bus.core_reset = core_reset_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_core_memory.sv
// tb_core_memory: directed bench for core_memory. Instance A (8 IM / 16 DM words) is
// tracked cycle by cycle against a behavioural model; instance B (4 IM / 8 DM words)
// covers the full-memory load without a last marker.
module tb_core_memory;
    import core_memory_pkg::*;

    localparam int unsigned ImA = 8;
    localparam int unsigned DmA = 16;
    localparam int unsigned ImB = 4;
    localparam int unsigned DmB = 8;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    core_memory_if ifa ();
    core_memory_if ifb ();

    core_memory #(.IM_WORDS(ImA), .DM_WORDS(DmA)) u_dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (ifa)
    );

    core_memory #(.IM_WORDS(ImB), .DM_WORDS(DmB)) u_dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of instance A: phase 0 clear, 1 load, 2 run.
    bit          m_live = 1'b0;
    int          m_phase;
    int          m_clear_left;
    int          m_wptr;
    bit          m_fault;
    logic [31:0] m_im [ImA];
    bit          m_im_known [ImA];
    logic [31:0] m_dm [DmA];
    logic [31:0] m_exp_im;
    logic [31:0] m_exp_dm;
    bit          m_exp_im_known;

    always @(posedge clk) begin
        if (rst_a) begin
            m_live         = 1'b1;
            m_phase        = 0;
            m_clear_left   = DmA;
            m_wptr         = 0;
            m_fault        = 1'b0;
            m_exp_im       = '0;
            m_exp_dm       = '0;
            m_exp_im_known = 1'b1;
            for (int i = 0; i < ImA; i++) m_im_known[i] = 1'b0;
        end else if (m_live) begin
            m_exp_im       = '0;
            m_exp_dm       = '0;
            m_exp_im_known = 1'b1;
            if (m_phase == 0) begin
                m_dm[DmA - m_clear_left] = '0;
                m_clear_left--;
                if (m_clear_left == 0) m_phase = 1;
            end else if (m_phase == 1) begin
                if (ifa.ld_valid) begin
                    m_im[m_wptr]       = ifa.ld_data;
                    m_im_known[m_wptr] = 1'b1;
                    if (ifa.ld_last) begin
                        m_phase = 2;
                    end else if (m_wptr == ImA - 1) begin
                        m_fault = 1'b1;
                        m_phase = 2;
                    end
                    m_wptr++;
                end
            end else begin
                if (ifa.addIM < 4 * ImA) begin
                    m_exp_im       = m_im[int'(ifa.addIM >> 2)];
                    m_exp_im_known = m_im_known[int'(ifa.addIM >> 2)];
                end else begin
                    m_fault = 1'b1;
                end
                if (ifa.addDM < 4 * DmA) m_exp_dm = m_dm[int'(ifa.addDM >> 2)];
                else m_fault = 1'b1;
                if (ifa.wenDM) begin
                    if (ifa.addDM % 4 == 0 && ifa.addDM < 4 * DmA)
                        m_dm[int'(ifa.addDM >> 2)] = ifa.dataOUT;
                    else
                        m_fault = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model core_reset", 32'(ifa.core_reset), 32'(m_phase != 2));
            check("model ld_ready", 32'(ifa.ld_ready), 32'(m_phase == 1));
            check("model fault", 32'(ifa.fault), 32'(m_fault));
            check("model dataDM", ifa.dataDM, m_exp_dm);
            if (m_exp_im_known) check("model dataIM", ifa.dataIM, m_exp_im);
        end
    end

    logic [31:0] prog      [3] = '{32'h20010005, 32'h20020007, 32'hFC00003F};
    logic [31:0] partial   [2] = '{32'h11111111, 32'h22222222};
    logic [31:0] reload    [5] = '{32'hA0000001, 32'hA0000002, 32'hA0000003,
                                   32'hA0000004, 32'hA0000005};

    task automatic load_a(input logic [31:0] w, input logic last);
        ifa.ld_valid = 1'b1;
        ifa.ld_data  = w;
        ifa.ld_last  = last;
        tick();
        ifa.ld_valid = 1'b0;
        ifa.ld_last  = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.addIM = '0; ifa.addDM = '0; ifa.wenDM = 1'b0; ifa.dataOUT = '0;
        ifa.ld_valid = 1'b0; ifa.ld_data = '0; ifa.ld_last = 1'b0;
        ifb.addIM = '0; ifb.addDM = '0; ifb.wenDM = 1'b0; ifb.dataOUT = '0;
        ifb.ld_valid = 1'b0; ifb.ld_data = '0; ifb.ld_last = 1'b0;
        tick();
        tick();
        check("reset core_reset", 32'(ifa.core_reset), 32'd1);
        check("reset ld_ready", 32'(ifa.ld_ready), 32'd0);
        check("reset fault", 32'(ifa.fault), 32'd0);
        check("reset dataIM", ifa.dataIM, 32'd0);
        check("reset dataDM", ifa.dataDM, 32'd0);
        rst_a = 1'b0;

        // Clear phase lasts exactly DmA cycles.
        for (int i = 0; i < DmA; i++) begin
            check("clear ld_ready", 32'(ifa.ld_ready), 32'd0);
            check("clear core_reset", 32'(ifa.core_reset), 32'd1);
            tick();
        end
        check("load ld_ready", 32'(ifa.ld_ready), 32'd1);

        for (int i = 0; i < 3; i++) load_a(prog[i], i == 2);
        check("run core_reset", 32'(ifa.core_reset), 32'd0);
        check("run ld_ready", 32'(ifa.ld_ready), 32'd0);
        ifa.addIM = 32'h8;
        tick();
        check("fetch 0x8", ifa.dataIM, 32'hFC00003F);
        ifa.addIM = 32'h4;
        tick();
        check("fetch 0x4", ifa.dataIM, 32'h20020007);

        // Store then read back; same-cycle read sees old (cleared) data.
        ifa.addDM = 32'h10; ifa.wenDM = 1'b1; ifa.dataOUT = 32'hDEADBEEF;
        tick();
        check("rbw old data", ifa.dataDM, 32'h0);
        ifa.wenDM = 1'b0;
        tick();
        check("store readback", ifa.dataDM, 32'hDEADBEEF);
        check("no fault yet", 32'(ifa.fault), 32'd0);

        // Misaligned store is dropped and flags fault.
        ifa.addDM = 32'h12; ifa.wenDM = 1'b1; ifa.dataOUT = 32'h12345678;
        tick();
        ifa.wenDM = 1'b0; ifa.addDM = 32'h10;
        tick();
        check("misaligned fault", 32'(ifa.fault), 32'd1);
        check("misaligned DM[4]", ifa.dataDM, 32'hDEADBEEF);
        repeat (3) tick();
        check("fault sticky", 32'(ifa.fault), 32'd1);

        // Reset, partially load, reset mid-load, then reload.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("re-reset fault", 32'(ifa.fault), 32'd0);
        repeat (DmA) tick();
        for (int i = 0; i < 2; i++) load_a(partial[i], 1'b0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("midload ld_ready", 32'(ifa.ld_ready), 32'd0);
        check("midload core_reset", 32'(ifa.core_reset), 32'd1);
        repeat (DmA) tick();
        check("reload ld_ready", 32'(ifa.ld_ready), 32'd1);
        for (int i = 0; i < 5; i++) load_a(reload[i], i == 4);
        check("reload core_reset", 32'(ifa.core_reset), 32'd0);
        check("reload fault", 32'(ifa.fault), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ifa.addIM = 32'(4 * i);
            tick();
            check("reload fetch", ifa.dataIM, reload[i]);
        end
        ifa.addDM = 32'h10;
        tick();
        check("DM cleared", ifa.dataDM, 32'h0);

        // Out-of-range fetch returns 0 and faults.
        ifa.addIM = 32'h20;
        tick();
        check("oor fetch data", ifa.dataIM, 32'h0);
        check("oor fetch fault", 32'(ifa.fault), 32'd1);
        ifa.addIM = '0;

        // Instance B: four words with no last marker fill IM and force RUN.
        rst_b = 1'b0;
        repeat (DmB) tick();
        check("B ld_ready", 32'(ifb.ld_ready), 32'd1);
        for (int i = 0; i < ImB; i++) begin
            ifb.ld_valid = 1'b1;
            ifb.ld_data  = 32'hB0000000 + 32'(i);
            tick();
            if (i < ImB - 1) begin
                check("B loading core_reset", 32'(ifb.core_reset), 32'd1);
                check("B loading fault", 32'(ifb.fault), 32'd0);
            end else begin
                check("B full fault", 32'(ifb.fault), 32'd1);
                check("B full core_reset", 32'(ifb.core_reset), 32'd0);
                check("B full ld_ready", 32'(ifb.ld_ready), 32'd0);
            end
        end
        ifb.ld_valid = 1'b0;
        ifb.addIM = 32'hC;
        tick();
        check("B fetch last", ifb.dataIM, 32'hB0000003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
